// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

    localparam int unsigned I2S_SLOT_WIDTH = 32;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_e;

    typedef logic [I2S_SLOT_WIDTH-1:0] i2s_sample_t;

endpackage

// File: rtl/i2s_edge_detect.sv
// Registers a slow synchronous level and flags its rising edge for one cycle.
module i2s_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic rise_c_o
);

    logic level_q;

    // Remember the level from the previous cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_c_o = level_i & ~level_q;

endmodule

// File: rtl/i2s_axis_receiver.sv
// I2S deserialiser presenting each channel slot as an AXI4-Stream beat.
// tlast marks the right-channel (ws=1) sample.
module i2s_axis_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = I2S_SLOT_WIDTH,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_aresetn,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  sck,
    input  logic                  ws,
    input  logic                  sd
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  bit_stb;
    logic                  word_end;
    logic                  bit_room;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift_ins;

    i2s_ch_e               ws_prev_q, ws_prev_d;
    logic                  synced_q,  synced_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;

    logic                  tvalid_q,  tvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q,   tdata_d;
    i2s_ch_e               tlast_q,   tlast_d;

    i2s_edge_detect u_sck_edge (
        .clk_i    (m_axis_aclk),
        .rst_ni   (m_axis_aresetn),
        .level_i  (sck),
        .rise_c_o (bit_stb)
    );

    // Current word with this strobe's sd bit placed MSB-first, if there is room.
    always_comb begin
        bit_room  = (cnt_q < CNT_WIDTH'(DATA_WIDTH));
        bit_idx   = IDX_W'(DATA_WIDTH - 1) - IDX_W'(cnt_q);
        shift_ins = shift_q;
        if (bit_room) begin
            shift_ins[bit_idx] = sd;
        end
    end

    // The bit sampled on a ws change still belongs to the word that just ended.
    assign word_end = bit_stb & (i2s_ch_e'(ws) != ws_prev_q);

    // Deserialiser next state: accumulate bits, restart on each slot boundary.
    always_comb begin
        ws_prev_d = ws_prev_q;
        synced_d  = synced_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        if (bit_stb) begin
            if (word_end) begin
                shift_d   = '0;
                cnt_d     = '0;
                ws_prev_d = i2s_ch_e'(ws);
                synced_d  = 1'b1;
            end else begin
                shift_d = shift_ins;
                if (bit_room) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Output register: a new word always wins, otherwise a transfer empties it.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        if (word_end && synced_q) begin
            tvalid_d = 1'b1;
            tdata_d  = shift_ins;
            tlast_d  = ws_prev_q;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            ws_prev_q <= CH_LEFT;
            synced_q  <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tlast_q   <= CH_LEFT;
        end else begin
            ws_prev_q <= ws_prev_d;
            synced_q  <= synced_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tlast_q   <= tlast_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = 1'(tlast_q);

endmodule

// File: tb/tb_i2s_axis_receiver.sv
// Self-checking bench for i2s_axis_receiver: fixed slot table, ramp, random
// slots against a bit-level reference model, plus handshake/reset sequences.
module tb_i2s_axis_receiver;
    import i2s_pkg::*;

    localparam int unsigned DW   = I2S_SLOT_WIDTH;
    localparam int          HALF = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m_axis_tready;
    logic          m_axis_tvalid;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          sck, ws, sd;

    int n_vec = 0;
    int n_err = 0;

    logic [32:0] got[$];
    logic [32:0] exp_q[$];

    logic m_bits[$];
    logic m_prev;
    bit   m_synced;
    logic cur_ch;

    typedef struct {
        logic        ch;
        int          nbits;
        logic [63:0] data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    i2s_axis_receiver dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .sck            (sck),
        .ws             (ws),
        .sd             (sd)
    );

    // Collect every accepted beat.
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready)
            got.push_back({m_axis_tlast, m_axis_tdata});
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (got time limit, required earlier finish)");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a slot is every bit up to and including the one that
    // arrives with a changed ws; its first DW bits form the left-justified word.
    task automatic model_reset();
        m_bits.delete();
        m_prev   = 1'b0;
        m_synced = 0;
    endtask

    task automatic model_bit(input logic w, input logic d);
        logic [31:0] word;
        m_bits.push_back(d);
        if (w != m_prev) begin
            word = '0;
            for (int k = 0; k < m_bits.size() && k < int'(DW); k++)
                word[31-k] = m_bits[k];
            if (m_synced)
                exp_q.push_back({m_prev, word});
            m_synced = 1;
            m_bits.delete();
            m_prev = w;
        end
    endtask

    task automatic send_bit(input logic w, input logic d, input bit raise_rdy);
        ws  = w;
        sd  = d;
        sck = 1'b0;
        repeat (HALF) tick();
        sck = 1'b1;
        if (raise_rdy) m_axis_tready = 1'b1;
        model_bit(w, d);
        repeat (HALF) tick();
    endtask

    // Send nbits of data MSB-first; the last bit carries the next channel's ws.
    task automatic send_slot(input logic [63:0] data, input int nbits, input bit raise_last);
        for (int k = 0; k < nbits; k++) begin
            logic w;
            w = (k == nbits - 1) ? ~cur_ch : cur_ch;
            send_bit(w, data[63-k], raise_last && (k == nbits - 1));
        end
        cur_ch = ~cur_ch;
    endtask

    task automatic sync_up();
        for (int k = 0; k < 3; k++) send_bit(1'b0, 1'($urandom), 0);
        send_bit(1'b1, 1'b1, 0);
        cur_ch = 1'b1;
    endtask

    task automatic check_stream(input string name);
        int n;
        chk({name, " beat count"}, 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s beat %0d", name, i), 64'(got[i]), 64'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic ch_a;
        logic ch_b;

        tbl[0] = '{1'b1, 32, 64'h0000_0000_0000_0000, 32'h0000_0000};
        tbl[1] = '{1'b0, 32, 64'hFFFF_FFFF_0000_0000, 32'hFFFF_FFFF};
        tbl[2] = '{1'b1, 32, 64'hFFFF_FFFF_0000_0000, 32'hFFFF_FFFF};
        tbl[3] = '{1'b0, 16, 64'hABCD_0000_0000_0000, 32'hABCD_0000};
        tbl[4] = '{1'b1, 40, 64'h1234_5678_9A00_0000, 32'h1234_5678};
        tbl[5] = '{1'b0, 32, 64'h8000_0001_0000_0000, 32'h8000_0001};
        tbl[6] = '{1'b1,  1, 64'h8000_0000_0000_0000, 32'h8000_0000};
        tbl[7] = '{1'b0, 31, 64'hFFFF_FFFE_0000_0000, 32'hFFFF_FFFE};
        tbl[8] = '{1'b1, 33, 64'hDEAD_BEEF_8000_0000, 32'hDEAD_BEEF};

        rst_n = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0; m_axis_tready = 1'b1;
        cur_ch = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("reset tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("reset tdata",  64'(m_axis_tdata),  64'd0);
        chk("reset tlast",  64'(m_axis_tlast),  64'd0);
        rst_n = 1'b1;
        tick();

        // Table: preamble before the first ws edge is discarded.
        sync_up();
        chk("no beat before sync", 64'(got.size()), 64'd0);
        got.delete();
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("vec%0d channel order", i), 64'(cur_ch), 64'(tbl[i].ch));
            send_slot(tbl[i].data, tbl[i].nbits, 0);
        end
        repeat (4) tick();
        chk("table beat count", 64'(got.size()), 64'd9);
        for (int i = 0; i < 9 && i < got.size(); i++) begin
            chk($sformatf("vec%0d tdata", i), 64'(got[i][31:0]), 64'(tbl[i].exp_data));
            chk($sformatf("vec%0d tlast", i), 64'(got[i][32]),   64'(tbl[i].ch));
        end
        got.delete();
        exp_q.delete();

        // Ramp sweep, left channel first.
        for (int i = 0; i < 256; i++)
            send_slot({8'(i), 56'h0}, 32, 0);
        repeat (4) tick();
        check_stream("ramp");

        // Random slot lengths and data, with occasional ws glitches between strobes.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                sck = 1'b0;
                ws  = ~ws;
                repeat (3) tick();
                ws  = ~ws;
                tick();
            end
            send_slot({$urandom, $urandom}, int'($urandom_range(1, 40)), 0);
        end
        repeat (4) tick();
        check_stream("random");

        // Backpressure: second word overwrites the first, one beat on release.
        m_axis_tready = 1'b0;
        ch_a = cur_ch;
        send_slot(64'h1111_2222_0000_0000, 32, 0);
        chk("bp hold tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("bp hold tdata",  64'(m_axis_tdata),  64'h1111_2222);
        chk("bp hold tlast",  64'(m_axis_tlast),  64'(ch_a));
        ch_b = cur_ch;
        send_slot(64'h3333_4444_0000_0000, 32, 0);
        repeat (3) tick();
        chk("overrun tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("overrun tdata",  64'(m_axis_tdata),  64'h3333_4444);
        chk("overrun tlast",  64'(m_axis_tlast),  64'(ch_b));
        chk("overrun no beat", 64'(got.size()), 64'd0);
        m_axis_tready = 1'b1;
        tick();
        chk("release tvalid falls", 64'(m_axis_tvalid), 64'd0);
        repeat (3) tick();
        chk("release beat count", 64'(got.size()), 64'd1);
        if (got.size() > 0)
            chk("release beat", 64'(got[0]), {31'd0, ch_b, 32'h3333_4444});
        got.delete();
        exp_q.delete();

        // Transfer and new word in the same cycle: both words must be delivered.
        m_axis_tready = 1'b0;
        send_slot(64'h5555_6666_0000_0000, 32, 0);
        send_slot(64'h7777_8888_0000_0000, 32, 1);
        repeat (3) tick();
        chk("simul tvalid drained", 64'(m_axis_tvalid), 64'd0);
        check_stream("simul");

        // Mid-word reset clears outputs at once and requires a fresh ws edge.
        m_axis_tready = 1'b0;
        send_slot(64'h9999_AAAA_0000_0000, 32, 0);
        for (int k = 0; k < 5; k++) send_bit(cur_ch, 1'b1, 0);
        chk("pre-reset tvalid", 64'(m_axis_tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("async reset tdata",  64'(m_axis_tdata),  64'd0);
        chk("async reset tlast",  64'(m_axis_tlast),  64'd0);
        model_reset();
        got.delete();
        exp_q.delete();
        sck = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        send_bit(1'b1, 1'b1, 0);
        for (int k = 0; k < 10; k++) send_bit(1'b1, 1'($urandom), 0);
        chk("no beat after reset", 64'(got.size()), 64'd0);
        send_bit(1'b0, 1'b1, 0);
        cur_ch = 1'b0;
        send_slot(64'hCAFE_F00D_0000_0000, 32, 0);
        repeat (4) tick();
        check_stream("resync");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
